// File: rtl/pattern_serializer.sv
// pattern_serializer
//
// Serial test-pattern transmitter for the lab sequence-detector FSMs.
// On start it latches a parallel pattern and shifts it out MSB-first on `w`,
// one bit per clock. The pattern is sent repeat_cnt+1 times, with GAP idle
// cycles between copies, and progress is reported through busy, done and
// sent_count.
//
// Parameters:
//   PATTERN_LEN  bits per pattern (2..16)
//   GAP          idle cycles between repeats (0..15)
//   CNT_W        width of sent_count
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   start       request a job (sampled only in IDLE)
//   abort       synchronous cancel, highest priority after reset
//   pattern     bits to send, bit PATTERN_LEN-1 goes first
//   repeat_cnt  pattern is sent repeat_cnt+1 times
//   w           registered serial data bit
//   w_valid     high while w carries a pattern bit
//   busy        high from the first bit through the DONE cycle
//   done        one-cycle pulse after the last bit of the last repeat
//   sent_count  pattern bits consumed in the current or most recent job

module pattern_serializer #(
    parameter int PATTERN_LEN = 8,
    parameter int GAP         = 2,
    parameter int CNT_W       = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [PATTERN_LEN-1:0] pattern,
    input  logic [3:0]             repeat_cnt,
    output logic                   w,
    output logic                   w_valid,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       sent_count
);

    localparam int IDX_W = (PATTERN_LEN > 1) ? $clog2(PATTERN_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PATTERN_LEN - 1);
    localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t                   state, state_next;
    logic [PATTERN_LEN-1:0]   shift_reg, shift_next;
    logic [PATTERN_LEN-1:0]   saved_pat, saved_next;
    logic [IDX_W-1:0]         bit_idx, bit_idx_next;
    logic [3:0]               rep_left, rep_left_next;
    logic [3:0]               gap_cnt, gap_cnt_next;
    logic [CNT_W-1:0]         sent_next;
    logic                     w_next, w_valid_next, busy_next, done_next;

    // State and datapath registers. The outputs are registered copies of
    // values derived from the next state, so w always shows the MSB of the
    // shift register the moment the FSM sits in SHIFT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            shift_reg  <= '0;
            saved_pat  <= '0;
            bit_idx    <= '0;
            rep_left   <= '0;
            gap_cnt    <= '0;
            sent_count <= '0;
            w          <= 1'b0;
            w_valid    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            shift_reg  <= shift_next;
            saved_pat  <= saved_next;
            bit_idx    <= bit_idx_next;
            rep_left   <= rep_left_next;
            gap_cnt    <= gap_cnt_next;
            sent_count <= sent_next;
            w          <= w_next;
            w_valid    <= w_valid_next;
            busy       <= busy_next;
            done       <= done_next;
        end
    end

    // Next-state and datapath logic. In SHIFT the bit currently on w is the
    // one the detector samples at this edge, so sent_count counts it here.
    // After the last bit of a copy the shift register is reloaded from the
    // latched pattern; with GAP=0 the reload feeds the very next cycle.
    always_comb begin
        state_next    = state;
        shift_next    = shift_reg;
        saved_next    = saved_pat;
        bit_idx_next  = bit_idx;
        rep_left_next = rep_left;
        gap_cnt_next  = gap_cnt;
        sent_next     = sent_count;

        case (state)
            S_IDLE: begin
                if (start) begin
                    shift_next    = pattern;
                    saved_next    = pattern;
                    rep_left_next = repeat_cnt;
                    bit_idx_next  = '0;
                    gap_cnt_next  = '0;
                    sent_next     = '0;
                    state_next    = S_SHIFT;
                end
            end

            S_SHIFT: begin
                sent_next = sent_count + CNT_W'(1);
                if (bit_idx == LAST_IDX) begin
                    bit_idx_next = '0;
                    if (rep_left != 4'd0) begin
                        rep_left_next = rep_left - 4'd1;
                        shift_next    = saved_pat;
                        gap_cnt_next  = '0;
                        state_next    = (GAP > 0) ? S_GAP : S_SHIFT;
                    end else begin
                        shift_next = shift_reg << 1;
                        state_next = S_DONE;
                    end
                end else begin
                    bit_idx_next = bit_idx + IDX_W'(1);
                    shift_next   = shift_reg << 1;
                end
            end

            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_next = '0;
                    state_next   = S_SHIFT;
                end else begin
                    gap_cnt_next = gap_cnt + 4'd1;
                end
            end

            S_DONE: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Abort freezes the datapath (sent_count keeps its value) and
        // returns to IDLE; it also wins over a simultaneous start.
        if (abort) begin
            state_next    = S_IDLE;
            shift_next    = shift_reg;
            saved_next    = saved_pat;
            bit_idx_next  = bit_idx;
            rep_left_next = rep_left;
            gap_cnt_next  = gap_cnt;
            sent_next     = sent_count;
        end
    end

    // Output values for the cycle after the edge, decoded from the next state.
    always_comb begin
        w_next       = 1'b0;
        w_valid_next = 1'b0;
        busy_next    = 1'b0;
        done_next    = 1'b0;

        case (state_next)
            S_SHIFT: begin
                w_next       = shift_next[PATTERN_LEN-1];
                w_valid_next = 1'b1;
                busy_next    = 1'b1;
            end
            S_GAP: begin
                busy_next = 1'b1;
            end
            S_DONE: begin
                busy_next = 1'b1;
                done_next = 1'b1;
            end
            default: begin
                busy_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pattern_serializer.sv
// tb_pattern_serializer
//
// Self-checking bench for pattern_serializer. One instance uses GAP=2, a
// second uses GAP=0 for the back-to-back and detector stream checks.
// Expected serial bits are pushed into a queue when a job is launched and
// popped whenever the design presents a valid bit.

module tb_pattern_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, abort;
    logic [7:0]  pattern;
    logic [3:0]  repeat_cnt;
    logic        w, w_valid, busy, done;
    logic [11:0] sent_count;

    logic        b_start, b_abort;
    logic [7:0]  b_pattern;
    logic [3:0]  b_repeat_cnt;
    logic        b_w, b_w_valid, b_busy, b_done;
    logic [11:0] b_sent_count;

    int compared   = 0;
    int mismatched = 0;
    bit exp_q[$];

    typedef struct {
        logic [7:0] pat;
        logic [3:0] rep;
        int         abort_at;
        bit         poke_start;
        int         exp_sent;
        int         exp_busy;
        int         exp_done;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    pattern_serializer #(.PATTERN_LEN(8), .GAP(2), .CNT_W(12)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .pattern    (pattern),
        .repeat_cnt (repeat_cnt),
        .w          (w),
        .w_valid    (w_valid),
        .busy       (busy),
        .done       (done),
        .sent_count (sent_count)
    );

    pattern_serializer #(.PATTERN_LEN(8), .GAP(0), .CNT_W(12)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .start      (b_start),
        .abort      (b_abort),
        .pattern    (b_pattern),
        .repeat_cnt (b_repeat_cnt),
        .w          (b_w),
        .w_valid    (b_w_valid),
        .busy       (b_busy),
        .done       (b_done),
        .sent_count (b_sent_count)
    );

    // One comparison: counts it, reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Launch a job on the GAP=2 instance; called on a falling edge.
    task automatic applyStimulus(input logic [7:0] pat, input logic [3:0] rep);
        pattern    = pat;
        repeat_cnt = rep;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        pattern    = 8'($urandom);
        repeat_cnt = 4'($urandom);
    endtask

    // Run one table record to completion, scoring every sampled cycle.
    task automatic runJob(input vec_t v, input int idx);
        int    busy_cycles;
        int    done_seen;
        int    bits_seen;
        bit    was_busy;
        bit    timed_out;
        string tag;
        busy_cycles = 0;
        done_seen   = 0;
        bits_seen   = 0;
        was_busy    = 1'b0;
        timed_out   = 1'b1;
        tag         = $sformatf("job%0d", idx);

        for (int r = 0; r <= int'(v.rep); r++)
            for (int i = 7; i >= 0; i--)
                if (v.abort_at < 0 || (r * 8 + (7 - i)) <= v.abort_at)
                    exp_q.push_back(v.pat[i]);

        applyStimulus(v.pat, v.rep);

        for (int c = 0; c < 400; c++) begin
            if (busy) begin
                busy_cycles++;
                was_busy = 1'b1;
            end
            if (done) done_seen++;
            if (w_valid) begin
                bits_seen++;
                if (exp_q.size() == 0)
                    checkOutput({tag, " extra bit"}, 32'd1, 32'd0);
                else
                    checkOutput({tag, " w"}, 32'(w), 32'(exp_q.pop_front()));
            end else begin
                checkOutput({tag, " w idle"}, 32'(w), 32'd0);
            end
            if (was_busy && !busy) begin
                timed_out = 1'b0;
                break;
            end
            abort = (v.abort_at >= 0 && w_valid && bits_seen == v.abort_at + 1);
            if (v.poke_start && w_valid && bits_seen == 3) begin
                start      = 1'b1;
                pattern    = ~v.pat;
                repeat_cnt = 4'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        abort = 1'b0;
        start = 1'b0;

        checkOutput({tag, " timeout"}, 32'(timed_out), 32'd0);
        checkOutput({tag, " busy cycles"}, 32'(busy_cycles), 32'(v.exp_busy));
        checkOutput({tag, " done pulses"}, 32'(done_seen), 32'(v.exp_done));
        checkOutput({tag, " sent_count"}, 32'(sent_count), 32'(v.exp_sent));
        checkOutput({tag, " bits left"}, 32'(exp_q.size()), 32'd0);
        checkOutput({tag, " w_valid after"}, 32'(w_valid), 32'd0);
        exp_q.delete();
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        logic [15:0] stream;
        logic [15:0] fire;
        int          nbits, run, busy_b, done_b;
        bit          bubble, ended_valid, was_busy_b, last_bit, timeout_b;

        reset = 1'b1;
        start = 1'b0;  abort = 1'b0;  pattern = '0;  repeat_cnt = '0;
        b_start = 1'b0; b_abort = 1'b0; b_pattern = '0; b_repeat_cnt = '0;

        vecs[0] = '{8'b1111_0000, 4'd0,  -1, 1'b0,   8,   9, 1};
        vecs[1] = '{8'b1010_0011, 4'd2,  -1, 1'b0,  24,  29, 1};
        vecs[2] = '{8'b1100_1010, 4'd0,   5, 1'b0,   5,   6, 0};
        vecs[3] = '{8'b0101_0110, 4'd2,  12, 1'b0,  12,  15, 0};
        vecs[4] = '{8'b0110_1001, 4'd1,  -1, 1'b1,  16,  19, 1};
        vecs[5] = '{8'b1000_0001, 4'd15, -1, 1'b0, 128, 159, 1};

        #1;
        checkOutput("reset w", 32'(w), 32'd0);
        checkOutput("reset w_valid", 32'(w_valid), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset sent_count", 32'(sent_count), 32'd0);

        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) runJob(vecs[i], i);

        // start and abort together in IDLE: abort wins.
        @(negedge clk);
        start = 1'b1; abort = 1'b1; pattern = 8'hAA; repeat_cnt = 4'd0;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checkOutput("start+abort busy", 32'(busy), 32'd0);
        checkOutput("start+abort w_valid", 32'(w_valid), 32'd0);
        @(negedge clk);
        checkOutput("start+abort still idle", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of SHIFT.
        applyStimulus(8'hFF, 4'd3);
        @(negedge clk);
        checkOutput("pre-reset w_valid", 32'(w_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async reset w", 32'(w), 32'd0);
        checkOutput("async reset w_valid", 32'(w_valid), 32'd0);
        checkOutput("async reset busy", 32'(busy), 32'd0);
        checkOutput("async reset done", 32'(done), 32'd0);
        checkOutput("async reset sent_count", 32'(sent_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("post-reset busy", 32'(busy), 32'd0);
        checkOutput("post-reset w_valid", 32'(w_valid), 32'd0);

        // GAP=0 instance: contiguous repeat and detector stream.
        stream = '0; fire = '0; nbits = 0; run = 0; busy_b = 0; done_b = 0;
        bubble = 1'b0; ended_valid = 1'b0; was_busy_b = 1'b0; last_bit = 1'b0;
        timeout_b = 1'b1;
        b_pattern = 8'b0000_1111; b_repeat_cnt = 4'd1; b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0; b_pattern = 8'($urandom); b_repeat_cnt = 4'($urandom);
        for (int c = 0; c < 40; c++) begin
            if (b_busy) begin
                busy_b++;
                was_busy_b = 1'b1;
            end
            if (b_done) done_b++;
            if (b_w_valid) begin
                if (ended_valid) bubble = 1'b1;
                stream = {stream[14:0], b_w};
                if (nbits > 0 && b_w == last_bit) run++;
                else run = 1;
                last_bit = b_w;
                if (run == 4 && nbits < 16) fire[nbits] = 1'b1;
                nbits++;
            end else if (nbits > 0) begin
                ended_valid = 1'b1;
            end
            if (was_busy_b && !b_busy) begin
                timeout_b = 1'b0;
                break;
            end
            @(negedge clk);
        end
        checkOutput("b2b timeout", 32'(timeout_b), 32'd0);
        checkOutput("b2b stream", 32'(stream), 32'h0F0F);
        checkOutput("b2b bit count", 32'(nbits), 32'd16);
        checkOutput("b2b bubble", 32'(bubble), 32'd0);
        checkOutput("b2b busy cycles", 32'(busy_b), 32'd17);
        checkOutput("b2b done pulses", 32'(done_b), 32'd1);
        checkOutput("b2b sent_count", 32'(b_sent_count), 32'd16);
        checkOutput("detector fire mask", 32'(fire), 32'h8888);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
